io_input_conditioner: RTL and testbench



---
 rtl/cpu_io_pkg.sv | 17 +
 rtl/io_debounce.sv | 63 ++++++
 rtl/io_input_conditioner.sv | 118 +++++++++++
 tb/tb_io_input_conditioner.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU input-port conditioning logic.
package cpu_io_pkg;

    // Width of the switch bus presented to the CPU.
    localparam int IO_DATA_W = 8;

    // Debounce length for real hardware builds: 20 ms at a 50 MHz clk.
    localparam int IO_DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VALID    = 2'd1,
        WAIT_REL = 2'd2
    } io_in_state_t;

endpackage

// File: rtl/io_debounce.sv
// Single-bit 2-flop synchroniser plus debounce counter.
// clean follows the synced input only after DEBOUNCE_CYCLES consecutive
// cycles of disagreement; rise is a registered one-cycle pulse that fires
// the cycle after clean goes 0->1.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             clean_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive cycles where the synced level disagrees with clean;
    // the cycle that would bring the count to DEBOUNCE_CYCLES accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (sync_2 != clean) begin
            if (cnt == CNT_LAST) begin
                clean <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered rising-edge detect on the debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            clean_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            clean_d <= clean;
            rise    <= clean & ~clean_d;
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Board button/switch conditioner feeding the CPU input port.
// Each debounced button press captures the synced switch value and offers
// it to the CPU as one valid/ack transaction.
// Optional build macro IO_INPUT_OVERRUN_EN adds a sticky 'overrun' output
// flagging presses dropped while a transaction was still pending.
module io_input_conditioner
    import cpu_io_pkg::*;
#(
    parameter int DATA_W          = IO_DATA_W,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] sw_raw,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    input  logic              in_ack,
`ifdef IO_INPUT_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              btn_clean
);

    // state    | meaning
    // IDLE     | no data pending, waiting for a press
    // VALID    | captured data offered to the CPU until in_ack
    // WAIT_REL | acked while button still held; wait for release

    io_in_state_t      state;
    io_in_state_t      state_next;
    logic [DATA_W-1:0] sw_sync_1;
    logic [DATA_W-1:0] sw_sync_2;
    logic              press;
    logic              capture;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw),
        .clean (btn_clean),
        .rise  (press)
    );

    // Two-flop synchroniser for the switch bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync_1 <= '0;
            sw_sync_2 <= '0;
        end else begin
            sw_sync_1 <= sw_raw;
            sw_sync_2 <= sw_sync_1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        in_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    capture    = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                in_valid = 1'b1;
                if (in_ack) begin
                    state_next = btn_clean ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!btn_clean) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Captured data register; only loads on an accepted press.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_data <= '0;
        end else if (capture) begin
            in_data <= sw_sync_2;
        end
    end

`ifdef IO_INPUT_OVERRUN_EN
    // Sticky flag: a press arrived while the CPU still owed an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (in_ack && state == VALID) begin
            overrun <= 1'b0;
        end else if (press && state == VALID) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed testbench for io_input_conditioner (DEBOUNCE_CYCLES = 4).
// Compile with +define+IO_INPUT_OVERRUN_EN to also check the overrun flag.
module tb_io_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic [7:0] sw_raw;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ack;
    logic       btn_clean;
`ifdef IO_INPUT_OVERRUN_EN
    logic       overrun;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    io_input_conditioner #(
        .DATA_W          (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ack    (in_ack),
`ifdef IO_INPUT_OVERRUN_EN
        .overrun   (overrun),
`endif
        .btn_clean (btn_clean)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present sw, press the button and count edges until in_valid (-1 on timeout).
    task automatic press(input logic [7:0] sw, output int lat);
        sw_raw = sw;
        tick(3);
        btn_raw = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (in_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic ack_pulse();
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
    endtask

    task automatic release_btn();
        btn_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        sw_raw  = 8'h00;
        in_ack  = 1'b0;
        tick(3);
        tests_run++;
        if (in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_valid got %b want 0", in_valid);
        end
        tests_run++;
        if (in_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_in_data got %h want 00", in_data);
        end
        tests_run++;
        if (btn_clean !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_btn_clean got %b want 0", btn_clean);
        end
`ifdef IO_INPUT_OVERRUN_EN
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_overrun got %b want 0", overrun);
        end
`endif
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_latency();
        int lat;
        press(8'hA5, lat);
        tests_run++;
        if (lat != 8) begin
            tests_failed++;
            $display("FAIL latency got %0d want 8", lat);
        end
        tests_run++;
        if (in_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL latency_data got %h want a5", in_data);
        end
        tests_run++;
        if (btn_clean !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_btn_clean got %b want 1", btn_clean);
        end
        tick(2);
        ack_pulse();
        tests_run++;
        if (in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_ack got %b want 0", in_valid);
        end
        release_btn();
    endtask

    task automatic test_glitch();
        int seen_clean = 0;
        int seen_valid = 0;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (btn_clean === 1'b1) seen_clean++;
            if (in_valid === 1'b1) seen_valid++;
            tick(1);
        end
        tests_run++;
        if (seen_clean != 0) begin
            tests_failed++;
            $display("FAIL glitch_btn_clean high for %0d cycles want 0", seen_clean);
        end
        tests_run++;
        if (seen_valid != 0) begin
            tests_failed++;
            $display("FAIL glitch_in_valid high for %0d cycles want 0", seen_valid);
        end
    endtask

    task automatic test_hold_data();
        int lat;
        int bad = 0;
        int seen_valid = 0;
        press(8'h3C, lat);
        tests_run++;
        if (lat != 8 || in_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL hold_capture got lat %0d data %h want 8 3c", lat, in_data);
        end
        sw_raw = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (in_data !== 8'h3C || in_valid !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_stable got %0d bad cycles (data %h) want 0 (3c)", bad, in_data);
        end
        ack_pulse();
        tests_run++;
        if (in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ack got %b want 0", in_valid);
        end
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (in_valid === 1'b1) seen_valid++;
        end
        tests_run++;
        if (seen_valid != 0) begin
            tests_failed++;
            $display("FAIL hold_no_repeat got %0d valid cycles want 0", seen_valid);
        end
        release_btn();
        tests_run++;
        if (btn_clean !== 1'b0 || in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release got clean %b valid %b want 0 0", btn_clean, in_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] d1;
        press(8'h3C, lat);
        d1 = in_data;
        ack_pulse();
        release_btn();
        in_ack = 1'b1;
        tick(3);
        in_ack = 1'b0;
        tests_run++;
        if (in_valid !== 1'b0 || in_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL idle_ack got valid %b data %h want 0 3c", in_valid, in_data);
        end
        press(8'h01, lat);
        tests_run++;
        if (d1 !== 8'h3C) begin
            tests_failed++;
            $display("FAIL b2b_first got %h want 3c", d1);
        end
        tests_run++;
        if (lat != 8 || in_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL b2b_second got lat %0d data %h want 8 01", lat, in_data);
        end
        ack_pulse();
        tests_run++;
        if (in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ack got %b want 0", in_valid);
        end
        release_btn();
    endtask

    task automatic test_dropped_press();
        int lat;
        press(8'h5A, lat);
        release_btn();
        tests_run++;
        if (in_valid !== 1'b1 || btn_clean !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_pending got valid %b clean %b want 1 0", in_valid, btn_clean);
        end
`ifdef IO_INPUT_OVERRUN_EN
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_before got %b want 0", overrun);
        end
`endif
        sw_raw  = 8'hC3;
        btn_raw = 1'b1;
        tick(10);
        tests_run++;
        if (in_valid !== 1'b1 || in_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL drop_data got valid %b data %h want 1 5a", in_valid, in_data);
        end
`ifdef IO_INPUT_OVERRUN_EN
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set got %b want 1", overrun);
        end
`endif
        ack_pulse();
        tests_run++;
        if (in_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_ack got %b want 0", in_valid);
        end
`ifdef IO_INPUT_OVERRUN_EN
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear got %b want 0", overrun);
        end
`endif
        release_btn();
    endtask

    task automatic test_reset_mid();
        int lat;
        press(8'h77, lat);
        tests_run++;
        if (in_valid !== 1'b1 || in_data !== 8'h77) begin
            tests_failed++;
            $display("FAIL rst_mid_setup got valid %b data %h want 1 77", in_valid, in_data);
        end
        reset = 1'b1;
        tick(1);
        tests_run++;
        if (in_valid !== 1'b0 || in_data !== 8'h00 || btn_clean !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_clear got valid %b data %h clean %b want 0 00 0",
                     in_valid, in_data, btn_clean);
        end
        reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (in_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat != 8 || in_data !== 8'h77) begin
            tests_failed++;
            $display("FAIL rst_mid_repress got lat %0d data %h want 8 77", lat, in_data);
        end
        ack_pulse();
        release_btn();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_hold_data();
        test_back_to_back();
        test_dropped_press();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
